// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: owns the register-file write port, shared by pipeline writeback and a long-latency unit.
// Latency: pipeline writes pass through combinationally; buffered results write no earlier than the next cycle.
// Backpressure: lu_ready drops while the pending buffer is full; pl_stall holds writeback for a forced drain.
// Optional feature: define REGWRITE_ARB_BYPASS_EN to let a result use an idle port in the same cycle.
module regwrite_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pl_we,
  input  logic [4:0]  pl_windex,
  input  logic [31:0] pl_win,
  output logic        pl_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_index,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        we,
  output logic [4:0]  windex,
  output logic [31:0] win,
  output logic [31:0] pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Pending buffer: circular FIFO; a dead entry still occupies its slot until it reaches the head.
  logic [DEPTH-1:0] ent_live;
  logic [4:0]       ent_idx [DEPTH];
  logic [31:0]      ent_dat [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       starve;

  logic empty;
  logic head_live;
  logic force_drain;
  logic pl_go;
  logic drain;
  logic pop;
  logic lu_acc;
  logic bypass;
  logic push;
  logic push_live;

  assign empty       = (count == '0);
  assign head_live   = !empty && ent_live[rd_ptr];
  assign force_drain = head_live && (starve == 4'(STARVE_LIMIT));
  assign pl_stall    = force_drain;
  assign lu_ready    = (count < CW'(DEPTH));
  assign pl_go       = pl_we && (pl_windex != 5'd0) && !force_drain;
  // The head uses the port either when forced or when the pipeline leaves it idle.
  assign drain       = force_drain || (!pl_go && head_live);
  // A squashed head never needs the port, so it leaves in any cycle.
  assign pop         = !empty && (drain || !head_live);
  // Results aimed at r0 are swallowed at acceptance.
  assign lu_acc      = lu_valid && lu_ready && (lu_index != 5'd0);
`ifdef REGWRITE_ARB_BYPASS_EN
  assign bypass      = empty && lu_valid && (lu_index != 5'd0) && !pl_go;
`else
  assign bypass      = 1'b0;
`endif
  assign push        = lu_acc && !bypass;
  // A same-cycle pipeline write to the same register already supersedes the incoming result.
  assign push_live   = !(pl_go && (lu_index == pl_windex));

  // Port mux: forced drain, then pipeline, then idle drain, then bypass.
  always_comb begin
    we     = 1'b0;
    windex = pl_windex;
    win    = pl_win;
    if (force_drain) begin
      we     = 1'b1;
      windex = ent_idx[rd_ptr];
      win    = ent_dat[rd_ptr];
    end else if (pl_go) begin
      we     = 1'b1;
    end else if (head_live) begin
      we     = 1'b1;
      windex = ent_idx[rd_ptr];
      win    = ent_dat[rd_ptr];
    end else if (bypass) begin
      we     = 1'b1;
      windex = lu_index;
      win    = lu_data;
    end
  end

  // Pending mask built only from registered live entries.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live[i]) pend_mask[ent_idx[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // Buffer state: squash, pop, push, occupancy and starvation tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_live <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      starve   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_idx[i] <= '0;
        ent_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pl_go && ent_live[i] && (ent_idx[i] == pl_windex)) ent_live[i] <= 1'b0;
      end
      if (pop) begin
        ent_live[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      if (push) begin
        ent_live[wr_ptr] <= push_live;
        ent_idx[wr_ptr]  <= lu_index;
        ent_dat[wr_ptr]  <= lu_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Non-empty without a pop means a live head that was blocked this cycle.
      if (empty || pop) begin
        starve <= '0;
      end else if (starve != 4'(STARVE_LIMIT)) begin
        starve <= starve + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed vector table, hand-written corner sequences, then random traffic vs a queue model.
// Latency: outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: random driver holds pl_* across a stall and lu_* while an offer is not accepted.
module tb_regwrite_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef REGWRITE_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pl_we;
  logic [4:0]  pl_windex;
  logic [31:0] pl_win;
  logic        pl_stall;
  logic        lu_valid;
  logic [4:0]  lu_index;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        we;
  logic [4:0]  windex;
  logic [31:0] win;
  logic [31:0] pend_mask;

  regwrite_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pl_we(pl_we), .pl_windex(pl_windex), .pl_win(pl_win), .pl_stall(pl_stall),
    .lu_valid(lu_valid), .lu_index(lu_index), .lu_data(lu_data), .lu_ready(lu_ready),
    .we(we), .windex(windex), .win(win), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Register file as written by the DUT port.
  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (rst_n && we) rf[windex] = win;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pl_we;  logic [4:0] pl_idx; logic [31:0] pl_dat;
    logic        lu_vld; logic [4:0] lu_idx; logic [31:0] lu_dat;
    logic        e_we;   logic [4:0] e_idx;  logic [31:0] e_win;
    logic [31:0] e_mask; logic       e_stall; logic      e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic [4:0] b, input logic [31:0] c,
                              input logic d, input logic [4:0] f, input logic [31:0] g,
                              input logic h, input logic [4:0] k, input logic [31:0] m,
                              input logic [31:0] n, input logic s, input logic r);
    vec_t v;
    v.pl_we = a; v.pl_idx = b; v.pl_dat = c;
    v.lu_vld = d; v.lu_idx = f; v.lu_dat = g;
    v.e_we = h; v.e_idx = k; v.e_win = m; v.e_mask = n; v.e_stall = s; v.e_rdy = r;
    return v;
  endfunction

  vec_t vt [23];

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit          live;
    logic [4:0]  idx;
    logic [31:0] dat;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  windex;
    logic [31:0] win;
    logic [31:0] mask;
    logic        stall;
    logic        rdy;
  } exp_t;

  ent_t mq [$];
  int   mstarve;

  // One clock cycle: expected outputs from the current inputs, then the state after the edge.
  task automatic model_cycle(output exp_t e);
    bit   head_live, go, byp, drained, pop, acc, was_empty;
    ent_t t;
    head_live = (mq.size() > 0) && mq[0].live;
    e.stall   = head_live && (mstarve == STARVE_LIMIT);
    e.rdy     = (mq.size() < DEPTH);
    e.mask    = '0;
    foreach (mq[i]) if (mq[i].live) e.mask[mq[i].idx] = 1'b1;
    go  = pl_we && (pl_windex != 5'd0) && !e.stall;
    byp = BYP && (mq.size() == 0) && lu_valid && (lu_index != 5'd0) && !go;
    e.we = 1'b0; e.windex = pl_windex; e.win = pl_win;
    if (e.stall) begin
      e.we = 1'b1; e.windex = mq[0].idx; e.win = mq[0].dat;
    end else if (go) begin
      e.we = 1'b1;
    end else if (head_live) begin
      e.we = 1'b1; e.windex = mq[0].idx; e.win = mq[0].dat;
    end else if (byp) begin
      e.we = 1'b1; e.windex = lu_index; e.win = lu_data;
    end
    acc       = lu_valid && e.rdy;
    was_empty = (mq.size() == 0);
    if (go) begin
      foreach (mq[i]) begin
        if (mq[i].idx == pl_windex) begin
          t = mq[i]; t.live = 1'b0; mq[i] = t;
        end
      end
    end
    drained = e.stall || (!go && head_live);
    pop     = !was_empty && (drained || !head_live);
    if (pop) void'(mq.pop_front());
    if (was_empty || pop) mstarve = 0;
    else if (mstarve < STARVE_LIMIT) mstarve++;
    if (acc && (lu_index != 5'd0) && !byp) begin
      t.live = !(go && (lu_index == pl_windex));
      t.idx  = lu_index;
      t.dat  = lu_data;
      mq.push_back(t);
    end
  endtask

  exp_t e;
  logic prev_stall, prev_rdy;
  int   pprob, lprob;

  initial begin
    rst_n = 1'b0; pl_we = 1'b0; pl_windex = '0; pl_win = '0;
    lu_valid = 1'b0; lu_index = '0; lu_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Table: collision, r0, starvation, full buffer, WAW squash (both flavours).
    vt[0]  = mk(0, 0, 0,     0, 0, 0,      0, 0, 0,      32'h0,   0, 1);
    vt[1]  = mk(1, 3, 'h33,  1, 7, 'h77,   1, 3, 'h33,   32'h0,   0, 1);
    vt[2]  = mk(0, 0, 0,     0, 0, 0,      1, 7, 'h77,   32'h80,  0, 1);
    vt[3]  = mk(1, 0, 'hE0,  1, 0, 'hE1,   0, 0, 'hE0,   32'h0,   0, 1);
    vt[4]  = mk(0, 0, 0,     0, 0, 0,      0, 0, 0,      32'h0,   0, 1);
    vt[5]  = mk(1, 10, 'hA,  1, 9, 'h99,   1, 10, 'hA,   32'h0,   0, 1);
    vt[6]  = mk(1, 10, 'hA,  0, 0, 0,      1, 10, 'hA,   32'h200, 0, 1);
    vt[7]  = mk(1, 10, 'hA,  0, 0, 0,      1, 10, 'hA,   32'h200, 0, 1);
    vt[8]  = mk(1, 10, 'hA,  0, 0, 0,      1, 10, 'hA,   32'h200, 0, 1);
    vt[9]  = mk(1, 10, 'hA,  0, 0, 0,      1, 10, 'hA,   32'h200, 0, 1);
    vt[10] = mk(1, 10, 'hA,  0, 0, 0,      1, 9, 'h99,   32'h200, 1, 1);
    vt[11] = mk(1, 10, 'hA,  0, 0, 0,      1, 10, 'hA,   32'h0,   0, 1);
    vt[12] = mk(1, 11, 'hB,  1, 1, 'h101,  1, 11, 'hB,   32'h0,   0, 1);
    vt[13] = mk(1, 11, 'hB,  1, 2, 'h102,  1, 11, 'hB,   32'h2,   0, 1);
    vt[14] = mk(1, 11, 'hB,  1, 3, 'h103,  1, 11, 'hB,   32'h6,   0, 0);
    vt[15] = mk(0, 0, 0,     1, 3, 'h103,  1, 1, 'h101,  32'h6,   0, 0);
    vt[16] = mk(0, 0, 0,     1, 3, 'h103,  1, 2, 'h102,  32'h4,   0, 1);
    vt[17] = mk(0, 0, 0,     0, 0, 0,      1, 3, 'h103,  32'h8,   0, 1);
    vt[18] = mk(1, 12, 'hC,  1, 4, 'h11,   1, 12, 'hC,   32'h0,   0, 1);
    vt[19] = mk(1, 4, 'h22,  0, 0, 0,      1, 4, 'h22,   32'h10,  0, 1);
    vt[20] = mk(0, 0, 0,     0, 0, 0,      0, 0, 0,      32'h0,   0, 1);
    vt[21] = mk(1, 5, 'h55,  1, 5, 'h66,   1, 5, 'h55,   32'h0,   0, 1);
    vt[22] = mk(0, 0, 0,     0, 0, 0,      0, 0, 0,      32'h0,   0, 1);

    // Reset state, and the write port following pl_* while in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", pl_stall, 0);
    chk("reset_ready", lu_ready, 1);
    chk("reset_mask", pend_mask, 0);
    chk("reset_we", we, 0);
    pl_we = 1'b1; pl_windex = 5'd6; pl_win = 32'h66;
    #1;
    chk("reset_we_follow", we, 1);
    chk("reset_windex_follow", windex, 6);
    pl_windex = 5'd0;
    #1;
    chk("reset_we_r0", we, 0);
    pl_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      pl_we = vt[i].pl_we; pl_windex = vt[i].pl_idx; pl_win = vt[i].pl_dat;
      lu_valid = vt[i].lu_vld; lu_index = vt[i].lu_idx; lu_data = vt[i].lu_dat;
      @(negedge clk);
      chk($sformatf("row%0d we", i), we, vt[i].e_we);
      chk($sformatf("row%0d windex", i), windex, vt[i].e_idx);
      chk($sformatf("row%0d win", i), win, vt[i].e_win);
      chk($sformatf("row%0d pend_mask", i), pend_mask, vt[i].e_mask);
      chk($sformatf("row%0d pl_stall", i), pl_stall, vt[i].e_stall);
      chk($sformatf("row%0d lu_ready", i), lu_ready, vt[i].e_rdy);
      @(posedge clk); #1;
    end
    chk("rf_r4_after_waw", rf[4], 32'h22);
    chk("rf_r5_after_waw", rf[5], 32'h55);
    chk("rf_r9_starved", rf[9], 32'h99);
    chk("rf_r0_untouched", rf[0], 32'h0);

    // Idle offer into an empty buffer.
    pl_we = 1'b0; pl_windex = '0; pl_win = '0;
    lu_valid = 1'b1; lu_index = 5'd5; lu_data = 32'hDEAD_BEEF;
    @(negedge clk);
`ifdef REGWRITE_ARB_BYPASS_EN
    chk("bypass_we", we, 1);
    chk("bypass_windex", windex, 5);
    chk("bypass_win", win, 32'hDEAD_BEEF);
    chk("bypass_mask", pend_mask, 0);
`else
    chk("idle_offer_we", we, 0);
    chk("idle_offer_mask", pend_mask, 0);
`endif
    @(posedge clk); #1;
    lu_valid = 1'b0;
    @(negedge clk);
`ifdef REGWRITE_ARB_BYPASS_EN
    chk("bypass_next_we", we, 0);
    chk("bypass_next_mask", pend_mask, 0);
`else
    chk("idle_next_mask", pend_mask, 32'h20);
    chk("idle_next_we", we, 1);
    chk("idle_next_windex", windex, 5);
    chk("idle_next_win", win, 32'hDEAD_BEEF);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_we", we, 0);
    chk("idle_after_mask", pend_mask, 0);
    @(posedge clk); #1;

    // Reset mid-cycle with two buffered entries.
    pl_we = 1'b1; pl_windex = 5'd20; pl_win = 32'h20;
    lu_valid = 1'b1; lu_index = 5'd21; lu_data = 32'h21;
    @(posedge clk); #1;
    lu_index = 5'd22; lu_data = 32'h22;
    @(posedge clk); #1;
    lu_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_mask", pend_mask, 32'h0060_0000);
    chk("rst_pre_ready", lu_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mask", pend_mask, 0);
    chk("rst_mid_ready", lu_ready, 1);
    chk("rst_mid_stall", pl_stall, 0);
    chk("rst_mid_we", we, 1);
    chk("rst_mid_windex", windex, 20);
    pl_we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rst_post%0d we", i), we, 0);
      chk($sformatf("rst_post%0d mask", i), pend_mask, 0);
    end

    // Random traffic against the queue model from a fresh reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    mstarve    = 0;
    prev_stall = 1'b0;
    prev_rdy   = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      case ((c / 300) % 4)
        0:       begin pprob = 90; lprob = 60; end
        1:       begin pprob = 60; lprob = 40; end
        2:       begin pprob = 30; lprob = 80; end
        default: begin pprob = 5;  lprob = 30; end
      endcase
      if (!prev_stall) begin
        pl_we     = ($urandom_range(99) < pprob);
        pl_windex = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
        pl_win    = $urandom;
      end
      if (!(lu_valid && !prev_rdy)) begin
        lu_valid = ($urandom_range(99) < lprob);
        lu_index = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
        lu_data  = $urandom;
      end
      @(negedge clk);
      model_cycle(e);
      chk("rand_we", we, e.we);
      chk("rand_windex", windex, e.windex);
      chk("rand_win", win, e.win);
      chk("rand_pend_mask", pend_mask, e.mask);
      chk("rand_pl_stall", pl_stall, e.stall);
      chk("rand_lu_ready", lu_ready, e.rdy);
      prev_stall = e.stall;
      prev_rdy   = e.rdy;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
